// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
//   Host-side command source for the system serial receive line. Accepts one
//   command per valid/ready handshake. Expands it into the controller's byte
//   sequence, and sends each byte as a UART frame:
//   start, 8 data bits LSB-first, optional parity, stop.
//
//   Optional build macro: UART_CMD_GAP_EN
//     Adds one idle bit time (line high) between consecutive frames of a
//     sequence. No gap follows the last frame.
//
// Ports:
//   CLK          framer clock
//   Reset        asynchronous active-low reset
//   cmd_valid    command presented
//   cmd_ready    command can be accepted (IDLE only, low while in reset)
//   cmd_type     0=RF write (AA), 1=RF read (BB), 2=ALU with operands (CC),
//                3=ALU without operands (DD)
//   cmd_addr     register file address
//   cmd_op_a     RF write data / ALU operand A
//   cmd_op_b     ALU operand B
//   cmd_fun      ALU function code
//   Parity_EN    append a parity bit to each frame
//   Parity_type  0=even, 1=odd
//   Prescale     clocks per bit (0 behaves as 1)
//   Tx_out       serial line, idles high
//   busy         sequence in progress (any state but IDLE)
//   frame_done   one-cycle pulse after the last stop bit
module uart_cmd_framer #(
    parameter int width = 8,
    parameter int PRE_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [3:0]       cmd_addr,
    input  logic [width-1:0] cmd_op_a,
    input  logic [width-1:0] cmd_op_b,
    input  logic [3:0]       cmd_fun,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    input  logic [PRE_W-1:0] Prescale,
    output logic             Tx_out,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
`ifdef UART_CMD_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

    state_t state, state_next;

    // Sequence context, captured on accept.
    logic [width-1:0] seq_bytes [4];
    logic [1:0]       last_idx;
    logic             par_en;
    logic             par_type;
    logic [PRE_W-1:0] pre_term;

    // Position within the sequence.
    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;

    logic             accept;
    logic             tick;
    logic             last_byte;
    logic [width-1:0] cur_byte;

    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (pre_cnt == pre_term);
    assign last_byte = (byte_idx == last_idx);
    assign cur_byte  = seq_bytes[byte_idx];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick && (bit_idx == 3'd7)) state_next = par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (last_byte) begin
                        state_next = DONE;
                    end else begin
`ifdef UART_CMD_GAP_EN
                        state_next = GAP;
`else
                        state_next = START;
`endif
                    end
                end
            end
`ifdef UART_CMD_GAP_EN
            GAP: begin
                if (tick) state_next = START;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from state so the line goes high as soon as
    // reset forces the state back to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        Tx_out = 1'b1;
        unique case (state)
            START:   Tx_out = 1'b0;
            DATA:    Tx_out = cur_byte[bit_idx];
            PARITY:  Tx_out = (^cur_byte) ^ par_type;
            default: Tx_out = 1'b1;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    // Qualified with Reset so the source sees "not ready" during reset
    // even though the state already reads IDLE.
    assign cmd_ready  = (state == IDLE) && Reset;

    // ------------------------------------------------------------------
    // Capture and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                seq_bytes[i] <= '0;
            end
            last_idx <= '0;
            par_en   <= 1'b0;
            par_type <= 1'b0;
            pre_term <= '0;
            pre_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else if (state == IDLE) begin
            pre_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            if (accept) begin
                par_en   <= Parity_EN;
                par_type <= Parity_type;
                // Terminal count is Prescale-1, with 0 treated as 1.
                pre_term <= (Prescale == '0) ? '0 : (Prescale - PRE_W'(1));
                unique case (cmd_type)
                    2'd0: begin
                        seq_bytes[0] <= width'(8'hAA);
                        seq_bytes[1] <= width'({4'b0, cmd_addr});
                        seq_bytes[2] <= cmd_op_a;
                        seq_bytes[3] <= '0;
                        last_idx     <= 2'd2;
                    end
                    2'd1: begin
                        seq_bytes[0] <= width'(8'hBB);
                        seq_bytes[1] <= width'({4'b0, cmd_addr});
                        seq_bytes[2] <= '0;
                        seq_bytes[3] <= '0;
                        last_idx     <= 2'd1;
                    end
                    2'd2: begin
                        seq_bytes[0] <= width'(8'hCC);
                        seq_bytes[1] <= cmd_op_a;
                        seq_bytes[2] <= cmd_op_b;
                        seq_bytes[3] <= width'({4'b0, cmd_fun});
                        last_idx     <= 2'd3;
                    end
                    default: begin
                        seq_bytes[0] <= width'(8'hDD);
                        seq_bytes[1] <= width'({4'b0, cmd_fun});
                        seq_bytes[2] <= '0;
                        seq_bytes[3] <= '0;
                        last_idx     <= 2'd1;
                    end
                endcase
            end
        end else if (state != DONE) begin
            pre_cnt <= tick ? '0 : (pre_cnt + PRE_W'(1));
            if ((state == DATA) && tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == STOP) && tick) begin
                byte_idx <= last_byte ? 2'd0 : (byte_idx + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer. Expected line waveform is built
// per command as a cycle-by-cycle bit queue from the frame format.
module tb_uart_cmd_framer;

    logic       CLK;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_op_a;
    logic [7:0] cmd_op_b;
    logic [3:0] cmd_fun;
    logic       Parity_EN;
    logic       Parity_type;
    logic [5:0] Prescale;
    logic       Tx_out;
    logic       busy;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    bit exp_q[$];

    uart_cmd_framer #(.width(8), .PRE_W(6)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_op_a   (cmd_op_a),
        .cmd_op_b   (cmd_op_b),
        .cmd_fun    (cmd_fun),
        .Parity_EN  (Parity_EN),
        .Parity_type(Parity_type),
        .Prescale   (Prescale),
        .Tx_out     (Tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expand a command into the expected Tx_out value for every clock
    // from the first start-bit cycle through the last stop-bit cycle.
    task automatic build_expected(input logic [1:0] t, input logic [3:0] addr,
                                  input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] fun, input logic pen,
                                  input logic ptype, input logic [5:0] presc);
        logic [7:0] bl[$];
        logic [7:0] by;
        int eff;
        bit bitv[$];
        case (t)
            2'd0:    bl = '{8'hAA, {4'h0, addr}, a};
            2'd1:    bl = '{8'hBB, {4'h0, addr}};
            2'd2:    bl = '{8'hCC, a, b, {4'h0, fun}};
            default: bl = '{8'hDD, {4'h0, fun}};
        endcase
        eff = (presc == 0) ? 1 : int'(presc);
        exp_q.delete();
        for (int i = 0; i < bl.size(); i++) begin
            by = bl[i];
            bitv.delete();
            bitv.push_back(1'b0);
            for (int j = 0; j < 8; j++) bitv.push_back(by[j]);
            if (pen) bitv.push_back((^by) ^ ptype);
            bitv.push_back(1'b1);
`ifdef UART_CMD_GAP_EN
            if (i != bl.size() - 1) bitv.push_back(1'b1);
`endif
            foreach (bitv[j]) begin
                for (int r = 0; r < eff; r++) exp_q.push_back(bitv[j]);
            end
        end
    endtask

    // Issue one command and check every cycle of the resulting sequence.
    // abort_at > 0 stops checking after that many sequence cycles.
    task automatic run_cmd(input logic [1:0] t, input logic [3:0] addr,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] fun, input logic pen,
                           input logic ptype, input logic [5:0] presc,
                           input int abort_at);
        int n;
        int waited;
        build_expected(t, addr, a, b, fun, pen, ptype, presc);
        n = exp_q.size();
        @(negedge CLK);
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        chk("ready_before_accept", cmd_ready, 1);
        cmd_type    = t;
        cmd_addr    = addr;
        cmd_op_a    = a;
        cmd_op_b    = b;
        cmd_fun     = fun;
        Parity_EN   = pen;
        Parity_type = ptype;
        Prescale    = presc;
        cmd_valid   = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            chk($sformatf("tx_cyc%0d", k), Tx_out, exp_q[k-1]);
            chk($sformatf("busy_cyc%0d", k), busy, 1);
            chk($sformatf("ready_cyc%0d", k), cmd_ready, 0);
            chk($sformatf("done_cyc%0d", k), frame_done, 0);
            if (abort_at == k) begin
                cmd_valid = 1'b0;
                return;
            end
            // Disturb every captured input; cycle 5 always carries a valid pulse.
            cmd_valid   = (k == 5) ? 1'b1 : 1'($urandom_range(0, 1));
            cmd_type    = 2'($urandom);
            cmd_addr    = 4'($urandom);
            cmd_op_a    = 8'($urandom);
            cmd_op_b    = 8'($urandom);
            cmd_fun     = 4'($urandom);
            Parity_EN   = 1'($urandom);
            Parity_type = 1'($urandom);
            Prescale    = 6'($urandom);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("done_pulse", frame_done, 1);
        chk("done_tx", Tx_out, 1);
        chk("done_busy", busy, 1);
        chk("done_ready", cmd_ready, 0);
        @(negedge CLK);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", frame_done, 0);
        chk("idle_tx", Tx_out, 1);
    endtask

    initial begin
        Reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_type    = '0;
        cmd_addr    = '0;
        cmd_op_a    = '0;
        cmd_op_b    = '0;
        cmd_fun     = '0;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        Prescale    = '0;

        repeat (3) @(negedge CLK);
        chk("rst_tx", Tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", frame_done, 0);
        Reset = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", cmd_ready, 1);

        // RF write, even then odd parity, 8 clocks per bit.
        run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b1, 1'b0, 6'd8, 0);
        run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b1, 1'b1, 6'd8, 0);
        // ALU with operands, no parity, 4 clocks per bit.
        run_cmd(2'd2, 4'h0, 8'h07, 8'h81, 4'h2, 1'b0, 1'b0, 6'd4, 0);
        // RF read with Prescale 0 (one clock per bit).
        run_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 6'd0, 0);
        run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h9, 1'b1, 1'b1, 6'd1, 0);
        // ALU with operands at 8 clocks per bit (exercises gaps when enabled).
        run_cmd(2'd2, 4'h0, 8'hA5, 8'h5A, 4'hE, 1'b0, 1'b0, 6'd8, 0);

        // Reset during the data bits of byte 1.
        run_cmd(2'd2, 4'h0, 8'hFF, 8'h00, 4'h1, 1'b0, 1'b0, 6'd4, 50);
        Reset = 1'b0;
        #1;
        chk("midrst_tx", Tx_out, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_done", frame_done, 0);
        @(negedge CLK);
        chk("midrst_hold_done", frame_done, 0);
        chk("midrst_hold_ready", cmd_ready, 0);
        Reset = 1'b1;
        @(negedge CLK);
        chk("midrst_release_ready", cmd_ready, 1);
        chk("midrst_release_tx", Tx_out, 1);
        run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 6'd4, 0);

        // Randomized commands.
        for (int i = 0; i < 25; i++) begin
            run_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                    4'($urandom), 1'($urandom), 1'($urandom),
                    6'($urandom_range(0, 9)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
Host-side command source that drives the system's serial Rx_IN line. It accepts one command per valid/ready handshake and expands it into the byte sequence the system controller decodes. Each byte is transmitted as a UART frame: start bit, 8 data bits LSB-first, an optional parity bit, and a stop bit. Serves as the upstream stimulus stage for the system receive path, both in the system bench and on the FPGA host bridge.

Parameters:
width, 8, data byte width (fixed at 8 for the command protocol)
PRE_W, 6, width of the Prescale input (number of clocks per bit)

Ports:
CLK  in  1  framer clock
Reset  in  1  asynchronous active-low reset
cmd_valid  in  1  a command is presented
cmd_ready  out  1  framer can accept a command (high only in IDLE)
cmd_type  in  2  0=RF write (0xAA), 1=RF read (0xBB), 2=ALU op with operands (0xCC), 3=ALU op without operands (0xDD)
cmd_addr  in  4  register file address
cmd_op_a  in  width  write data for RF write; operand A for ALU op with operands
cmd_op_b  in  width  operand B for ALU op with operands
cmd_fun  in  4  ALU function code
Parity_EN  in  1  insert a parity bit in each frame
Parity_type  in  1  0=even parity, 1=odd parity
Prescale  in  PRE_W  clocks per bit; a value of 0 is treated as 1
Tx_out  out  1  serial line, idles high
busy  out  1  a frame sequence is in progress
frame_done  out  1  one-cycle pulse after the stop bit of the last byte

Behaviour:
- Reset (async, active-low) values: Tx_out=1, cmd_ready=0 while Reset is low then 1 in IDLE, busy=0, frame_done=0, all counters 0, state=IDLE.
- Handshake: a command is accepted on a rising CLK edge where cmd_valid=1 and cmd_ready=1.
  - On accept, the framer captures all cmd_* inputs, Parity_EN, Parity_type and Prescale.
  - Changes to these inputs during a sequence have no effect on that sequence.
- Byte sequences (bytes sent in this order, the length is also captured on accept):
  - RF write: AA, {4'b0,addr}, op_a (3 bytes).
  - RF read: BB, {4'b0,addr} (2 bytes).
  - ALU op with operands: CC, op_a, op_b, {4'b0,fun} (4 bytes).
  - ALU op without operands: DD, {4'b0,fun} (2 bytes).
- FSM states: IDLE -> START -> DATA -> (PARITY if Parity_EN captured) -> STOP -> START for the next byte, or DONE after the last byte. DONE -> IDLE.
- Bit timing:
  - Each bit is held on Tx_out for exactly Prescale clocks, counted by a prescale counter from 0 to Prescale-1.
  - The state or bit advances when the counter reaches its terminal value.
  - The first cycle after accept is the first start-bit cycle, so Tx_out=0 starting on the clock edge following accept.
- DATA state: a 3-bit bit index 0..7 selects data bits LSB-first. The transition to PARITY/STOP happens at the terminal count of bit 7.
- Parity bit: XOR-reduce of the byte, XOR Parity_type.
- Byte index: a 2-bit byte index increments at the STOP terminal count and wraps to 0 when entering DONE.
- Frame length: 10 or 11 bits per byte. Total sequence length = bytes*(10+Parity_EN)*Prescale clocks.
- DONE lasts 1 cycle:
  - frame_done=1, Tx_out=1, busy=1.
  - The next cycle is IDLE with cmd_ready=1.
  - Minimum spacing between accepts = sequence length + 1 cycle.
- busy=1 in every state except IDLE. cmd_ready = (state==IDLE).
- cmd_valid asserted during busy: ignored, no queuing; the source must hold the command until ready.
- Prescale=1: every bit lasts 1 clock and the counter stays at 0.
- Reset mid-sequence: the line returns to 1 immediately (asynchronously) and the partial frame is abandoned. No frame_done is produced.

Optional Feature:
Macro UART_CMD_GAP_EN.
- Defined: adds a GAP state after every STOP except the last byte's. It holds Tx_out=1 for one extra bit time (Prescale clocks). Sequence length = bytes*(10+Parity_EN)*Prescale + (bytes-1)*Prescale.
- Undefined: the GAP state and its logic are absent; bytes are sent back-to-back.

Test Plan:
- Prescale=8, Parity_EN=1, even; RF write addr=5, op_a=0x3C -> bytes AA,05,3C. Parity bits 0,0,0. 264 clocks from accept to last stop end. frame_done is at clock 265 after accept.
- Same RF write with Parity_type=1 (odd) -> all three parity bits =1. Each frame is 11 bits of 8 clocks.
- Parity_EN=0, Prescale=4; ALU op with operands op_a=0x07, op_b=0x81, fun=2 -> CC,07,81,02 as 10-bit frames. 160 clocks total. cmd_ready is low throughout.
- Prescale=0; RF read addr=0xF -> BB,0F with every bit lasting 1 clock. A cmd_valid pulse at clock 5 is ignored.
- Reset asserted in DATA state of byte 1 -> Tx_out=1, busy=0 and cmd_ready=0 while in reset. After release: cmd_ready=1, and a new DD,03 sequence starts cleanly.
- With UART_CMD_GAP_EN, Prescale=8, parity off, ALU op with operands -> 3 idle gaps of 8 clocks between frames. Total 344 clocks.
